wb_scratchpad_slave: RTL

WB_SCRATCHPAD_SLAVE -- requirements
Module: wb_scratchpad_slave

---
 rtl/wb_scratchpad_pkg.sv | 24 ++
 rtl/wb_scratchpad_mem.sv | 46 ++++
 rtl/wb_scratchpad_slave.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wb_scratchpad_pkg.sv
// Shared definitions for the Wishbone scratchpad slave: FSM encoding,
// default geometry/timing and the event-counter helpers.
package wb_scratchpad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
  localparam int          DEF_DEPTH_WORDS = 256;
  localparam int          DEF_WAIT_STATES = 1;

  // Event counter width and wait-state counter width (0..15 wait states)
  localparam int CNT_W  = 16;
  localparam int WCNT_W = 4;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_scratchpad_mem.sv
// Scratchpad storage: one write port with per-byte enables and one read port
// with a registered (one-cycle) output. Each byte lane is its own array so
// the lane enables map straight onto block-RAM write enables.
module wb_scratchpad_mem
  import wb_scratchpad_pkg::*;
#(
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_ram [DEPTH_WORDS];
      logic [7:0] lane_q;

      // Byte-lane write, only when this lane is selected
      always_ff @(posedge clk) begin
        if (wr_be[gi]) begin
          lane_ram[wr_idx] <= wr_data[8*gi +: 8];
        end
      end

      // Registered read; holds its value until the next read is issued
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_q <= '0;
        end else if (rd_en) begin
          lane_q <= lane_ram[rd_idx];
        end
      end

      assign rd_data[8*gi +: 8] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/wb_scratchpad_slave.sv
// Wishbone scratchpad slave: a word-addressed RAM window at BASE_ADDR with a
// programmable number of wait states, bus-error reporting for out-of-window or
// misaligned accesses, and saturating write/read/error counters.
module wb_scratchpad_slave
  import wb_scratchpad_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int          WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_stall_o,
  output logic        err_irq_o,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [15:0] err_count
);

  localparam int                AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]       WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [WCNT_W-1:0] WS_INIT   = WCNT_W'(WAIT_STATES);

  state_t            state_reg, state_next;
  logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
  logic              ack_reg, ack_next;
  logic              err_reg, err_next;
  logic              stall_reg;
  logic              we_reg;
  logic [AW-1:0]     idx_reg;
  logic [31:0]       dat_reg;
  logic [3:0]        sel_reg;
  logic [CNT_W-1:0]  wr_cnt_reg, rd_cnt_reg, err_cnt_reg;

  logic [31:0]       req_off;
  logic              req_ok;
  logic [AW-1:0]     req_idx;
  logic              mem_wr, mem_rd;
  logic [AW-1:0]     mem_idx;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_sel;
  logic              wr_evt, rd_evt, err_evt;

  // Window check by offset so a window touching the top of the map cannot wrap
  assign req_off = wb_adr_i - BASE_ADDR;
  assign req_ok  = ({1'b0, req_off} < WIN_BYTES) && (wb_adr_i[1:0] == 2'b00);
  assign req_idx = req_off[AW+1:2];

  // State, wait counter and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      wcnt_reg  <= '0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      stall_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      stall_reg <= (state_next != IDLE);
    end
  end

  // Capture the request whenever one is presented in IDLE
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && wb_cyc_i && wb_stb_i) begin
      we_reg  <= wb_we_i;
      idx_reg <= req_idx;
      dat_reg <= wb_dat_i;
      sel_reg <= wb_sel_i;
    end
  end

  // Next state, response flags and the memory access that coincides with the response
  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_idx    = idx_reg;
    mem_wdata  = dat_reg;
    mem_sel    = sel_reg;
    wr_evt     = 1'b0;
    rd_evt     = 1'b0;
    err_evt    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          if (!req_ok) begin
            state_next = RESP;
            err_next   = 1'b1;
            err_evt    = 1'b1;
          end else if (WAIT_STATES == 0) begin
            // Zero wait states: access the RAM straight from the bus inputs
            state_next = RESP;
            ack_next   = 1'b1;
            mem_idx    = req_idx;
            mem_wdata  = wb_dat_i;
            mem_sel    = wb_sel_i;
            mem_wr     = wb_we_i;
            mem_rd     = !wb_we_i;
            wr_evt     = wb_we_i;
            rd_evt     = !wb_we_i;
          end else begin
            state_next = WAIT;
            wcnt_next  = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          // Master gave up: drop the access silently
          state_next = IDLE;
        end else if (wcnt_reg == WCNT_W'(1)) begin
          state_next = RESP;
          ack_next   = 1'b1;
          mem_wr     = we_reg;
          mem_rd     = !we_reg;
          wr_evt     = we_reg;
          rd_evt     = !we_reg;
        end else begin
          wcnt_next = wcnt_reg - WCNT_W'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Saturating event counters, bumped together with the response
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (wr_evt)  wr_cnt_reg  <= sat_inc(wr_cnt_reg);
      if (rd_evt)  rd_cnt_reg  <= sat_inc(rd_cnt_reg);
      if (err_evt) err_cnt_reg <= sat_inc(err_cnt_reg);
    end
  end

  wb_scratchpad_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_be   (mem_sel & {4{mem_wr & ~rst}}),
    .wr_idx  (mem_idx),
    .wr_data (mem_wdata),
    .rd_en   (mem_rd & ~rst),
    .rd_idx  (mem_idx),
    .rd_data (wb_dat_o)
  );

  assign wb_ack_o   = ack_reg;
  assign wb_err_o   = err_reg;
  assign err_irq_o  = err_reg;
  assign wb_stall_o = stall_reg;
  assign wr_count   = wr_cnt_reg;
  assign rd_count   = rd_cnt_reg;
  assign err_count  = err_cnt_reg;

endmodule
